// File: rtl/mul_div_pkg.sv
// rtl/mul_div_pkg.sv - shared width, op encodings and FSM states for the iterative mul/div unit
package mul_div_pkg;

    localparam int XLEN = 64;

    typedef enum logic [2:0] {
        OP_MUL   = 3'b000,
        OP_MULH  = 3'b001,
        OP_MULHU = 3'b010,
        OP_RSVD  = 3'b011,
        OP_DIV   = 3'b100,
        OP_DIVU  = 3'b101,
        OP_REM   = 3'b110,
        OP_REMU  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

endpackage

// File: rtl/mul_div_iter.sv
// rtl/mul_div_iter.sv - radix-2 iterative multiplier/divider with one shared adder
module mul_div_iter #(
    parameter int XLEN = mul_div_pkg::XLEN
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            START,
    input  logic [2:0]      OP,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT
);
    import mul_div_pkg::*;

    localparam int CW = $clog2(XLEN) + 1;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    op_e               op_q, op_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   result_q, result_d;

    // Shared datapath wires
    logic [XLEN:0]     add_a, add_b, sum;
    logic [2*XLEN-1:0] acc_next, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

    // Request decode wires
    op_e               op_in;
    logic              signed_in, is_div_in, is_rem_in, b_zero, ovf;
    logic [XLEN-1:0]   a_mag, b_mag;

    // Decode the incoming request: signedness, magnitudes and the short-circuit cases
    always_comb begin
        op_in     = op_e'(OP);
        signed_in = !(op_in == OP_MULHU || op_in == OP_DIVU || op_in == OP_REMU);
        is_div_in = OP[2];
        is_rem_in = OP[2] & OP[1];
        a_mag     = (signed_in && A[XLEN-1]) ? -A : A;
        b_mag     = (signed_in && B[XLEN-1]) ? -B : B;
        b_zero    = (B == '0);
        ovf       = signed_in && (A == {1'b1, {(XLEN-1){1'b0}}}) && (&B);
    end

    // One iteration step: add for shift-add multiply, trial subtract for restoring divide
    always_comb begin
        add_a = op_q[2] ? {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]} : {1'b0, acc_q[2*XLEN-1:XLEN]};
        add_b = op_q[2] ? ~{1'b0, opb_q} : {1'b0, opb_q};
        sum   = add_a + add_b + {{XLEN{1'b0}}, op_q[2]};
        if (op_q[2]) begin
            // Non-negative difference means the divisor fits: keep it and shift in a 1
            if (!sum[XLEN]) acc_next = {sum[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            else            acc_next = {add_a[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
            if (acc_q[0]) acc_next = {sum, acc_q[XLEN-1:1]};
            else          acc_next = {1'b0, acc_q[2*XLEN-1:1]};
        end
    end

    // Sign correction and result selection from the final iteration
    always_comb begin
        prod_fix = neg_q ? -acc_next : acc_next;
        quo_fix  = neg_q ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
        rem_fix  = neg_q ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
        case (op_q)
            OP_MULH, OP_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:   final_res = quo_fix;
            OP_REM, OP_REMU:   final_res = rem_fix;
            default:           final_res = prod_fix[XLEN-1:0];
        endcase
    end

    // Control FSM next-state and register updates
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        op_d     = op_q;
        neg_d    = neg_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    if (is_div_in && b_zero) begin
                        result_d = is_rem_in ? A : '1;
                        state_d  = ST_FINISH;
                    end else if (is_div_in && ovf) begin
                        result_d = is_rem_in ? '0 : A;
                        state_d  = ST_FINISH;
                    end else begin
                        acc_d   = {{XLEN{1'b0}}, a_mag};
                        opb_d   = b_mag;
                        op_d    = op_in;
                        neg_d   = signed_in && (is_rem_in ? A[XLEN-1] : (A[XLEN-1] ^ B[XLEN-1]));
                        cnt_d   = '0;
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                acc_d = acc_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(XLEN - 1)) begin
                    result_d = final_res;
                    state_d  = ST_FINISH;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign BUSY   = (state_q != ST_IDLE);
    assign DONE   = (state_q == ST_FINISH);
    assign RESULT = result_q;

endmodule

// File: tb/tb_mul_div_iter.sv
// tb/tb_mul_div_iter.sv - directed self-checking bench for mul_div_iter
module tb_mul_div_iter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic [2:0]  OP = 3'b000;
    logic [63:0] A = '0;
    logic [63:0] B = '0;
    logic        BUSY;
    logic        DONE;
    logic [63:0] RESULT;

    int total = 0;
    int bad   = 0;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

    mul_div_iter #(.XLEN(64)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .START  (START),
        .OP     (OP),
        .A      (A),
        .B      (B),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .RESULT (RESULT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp_v, input int lat,
                          input int poke);
        int cyc;
        bit busy_ok;
        @(negedge CLK);
        START = 1'b1; OP = op; A = a; B = b;
        @(negedge CLK);
        START = 1'b0; OP = ~op; A = ~a; B = b ^ 64'h5A5A_0000_0000_1234;
        cyc = 1;
        busy_ok = 1'b1;
        while (!DONE && cyc < 200) begin
            if (!BUSY) busy_ok = 1'b0;
            if (cyc == poke) begin
                START = 1'b1; OP = 3'b000; A = 64'd9; B = 64'd9;
            end else begin
                START = 1'b0;
            end
            @(negedge CLK);
            cyc++;
        end
        START = 1'b0;
        chk($sformatf("%s done", tag), {63'd0, DONE}, 64'd1);
        chk($sformatf("%s latency", tag), 64'(cyc), 64'(lat));
        chk($sformatf("%s busy", tag), {63'd0, busy_ok & BUSY}, 64'd1);
        chk($sformatf("%s result", tag), RESULT, exp_v);
        // START during FINISH must be ignored
        START = 1'b1; OP = 3'b000; A = 64'd2; B = 64'd2;
        @(negedge CLK);
        START = 1'b0;
        chk($sformatf("%s idle after", tag), {63'd0, BUSY | DONE}, 64'd0);
        chk($sformatf("%s held", tag), RESULT, exp_v);
    endtask

    initial begin
        #1;
        chk("reset busy", {63'd0, BUSY}, 64'd0);
        chk("reset done", {63'd0, DONE}, 64'd0);
        chk("reset result", RESULT, 64'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;

        run_op("mul 7*-3",     3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65, 0);
        run_op("mulh -1*-1",   3'b001, ONES, ONES, 64'd0, 65, 0);
        run_op("mulhu max",    3'b010, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 65, 0);
        run_op("mulh -2*3",    3'b001, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, ONES, 65, 0);
        run_op("mulhu 2^63*4", 3'b010, MINV, 64'd4, 64'd2, 65, 0);
        run_op("rsvd 6*7",     3'b011, 64'd6, 64'd7, 64'd42, 65, 0);
        run_op("div -20/3",    3'b100, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 65, 0);
        run_op("rem -20%3",    3'b110, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 65, 0);
        run_op("divu 100/7",   3'b101, 64'd100, 64'd7, 64'd14, 65, 0);
        run_op("remu 100%7",   3'b111, 64'd100, 64'd7, 64'd2, 65, 0);
        run_op("div 5/0",      3'b100, 64'd5, 64'd0, ONES, 1, 0);
        run_op("remu 5/0",     3'b111, 64'd5, 64'd0, 64'd5, 1, 0);
        run_op("div min/-1",   3'b100, MINV, ONES, MINV, 1, 0);
        run_op("rem min/-1",   3'b110, MINV, ONES, 64'd0, 1, 0);
        run_op("mul start10",  3'b000, 64'd3, 64'd5, 64'd15, 65, 10);

        // Result must stay put over idle cycles until the next accepted START
        repeat (5) @(negedge CLK);
        chk("idle hold result", RESULT, 64'd15);
        chk("idle hold busy", {63'd0, BUSY}, 64'd0);

        // Reset in the middle of a DIVU
        START = 1'b1; OP = 3'b101; A = 64'd1000; B = 64'd3;
        @(negedge CLK);
        START = 1'b0;
        repeat (29) @(negedge CLK);
        chk("pre-reset busy", {63'd0, BUSY}, 64'd1);
        RST = 1'b1;
        #1;
        chk("rst busy", {63'd0, BUSY}, 64'd0);
        chk("rst done", {63'd0, DONE}, 64'd0);
        chk("rst result", RESULT, 64'd0);
        begin
            bit saw_done;
            saw_done = 1'b0;
            repeat (3) begin
                @(negedge CLK);
                if (DONE) saw_done = 1'b1;
            end
            RST = 1'b0;
            repeat (40) begin
                @(negedge CLK);
                if (DONE) saw_done = 1'b1;
            end
            chk("rst no done", {63'd0, saw_done}, 64'd0);
        end
        run_op("post-rst 6*7", 3'b000, 64'd6, 64'd7, 64'd42, 65, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
